// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode handshake,
// execute redirect and the delivered-instruction counter.
interface ifetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr_count;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr, instr_pc, opcode, funct3, funct7, instr_count,
    input  instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr, instr_pc, opcode, funct3, funct7, instr_count,
    output instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifetch_unit.sv
// Single-outstanding instruction fetch: PC, one-entry output register with
// pre-split fields, and redirect squash of in-flight fetches.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_unit_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_instr_pc, w_instr_pc_nxt;
  logic [31:0] r_count, w_count_nxt;
  logic        r_valid, w_valid_nxt;
  logic        w_hs;

  assign w_hs = (r_state == HOLD) && r_valid && bus.instr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_instr_pc <= 32'h0;
      r_count    <= 32'h0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_count    <= w_count_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_count_nxt    = r_count;
    w_valid_nxt    = r_valid;
    // A handshake in HOLD counts even when a redirect squashes it in the same cycle.
    if (w_hs) w_count_nxt = r_count + 32'd1;
    if (bus.redirect_valid) begin
      w_pc_nxt    = bus.redirect_pc & ~32'h3;
      w_valid_nxt = 1'b0;
      w_instr_nxt = NOP_INSTR;
      case (r_state)
        REQ:     w_state_nxt = bus.imem_req_ready ? DRAIN : REQ;
        WAIT:    w_state_nxt = bus.imem_rsp_valid ? REQ : DRAIN;
        DRAIN:   w_state_nxt = bus.imem_rsp_valid ? REQ : DRAIN;
        default: w_state_nxt = REQ;
      endcase
    end else begin
      case (r_state)
        IDLE: w_state_nxt = REQ;
        REQ:  if (bus.imem_req_ready) w_state_nxt = WAIT;
        WAIT: if (bus.imem_rsp_valid) begin
          w_instr_nxt    = bus.imem_rsp_data;
          w_instr_pc_nxt = r_pc;
          w_valid_nxt    = 1'b1;
          w_pc_nxt       = r_pc + 32'd4;
          w_state_nxt    = HOLD;
        end
        HOLD: if (w_hs) begin
          w_valid_nxt = 1'b0;
          w_instr_nxt = NOP_INSTR;
          w_state_nxt = REQ;
        end
        DRAIN:   if (bus.imem_rsp_valid) w_state_nxt = REQ;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign bus.imem_req_valid = (r_state == REQ);
  assign bus.imem_req_addr  = r_pc;
  assign bus.instr_valid    = r_valid;
  assign bus.instr          = r_instr;
  assign bus.instr_pc       = r_instr_pc;
  assign bus.opcode         = r_instr[6:0];
  assign bus.funct3         = r_instr[14:12];
  assign bus.funct7         = r_instr[31:25];
  assign bus.instr_count    = r_count;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized + directed bench for ifetch_unit: memory responder, expected
// instruction-stream scoreboard and a second instance for PC wrap.
module tb_ifetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifetch_unit_if ifc ();
  ifetch_unit_if ifw ();

  ifetch_unit dut  (.clk(clk), .rst(rst), .bus(ifc));
  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutw (.clk(clk), .rst(rst), .bus(ifw));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Memory contents: address hash unless a directed word is planted.
  logic [31:0] ovr [logic [31:0]];
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  // ---------------- memory responder ----------------
  bit          pend = 0;
  bit          m_acc = 0;
  bit          mem_hold = 0;
  int          dly = 0;
  int          rdy_pct = 100, lat_lo = 0, lat_hi = 0;
  logic [31:0] paddr = 0;

  initial begin
    ifc.imem_req_ready = 1'b0;
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_data  = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (m_acc) begin
        pend = 1;
        dly  = $urandom_range(lat_hi, lat_lo);
      end
      ifc.imem_rsp_valid = 1'b0;
      ifc.imem_rsp_data  = $urandom;
      if (pend) begin
        if (dly == 0) begin
          ifc.imem_rsp_valid = 1'b1;
          ifc.imem_rsp_data  = memf(paddr);
          pend = 0;
        end else dly--;
      end
      ifc.imem_req_ready = !mem_hold && ($urandom_range(99, 0) < rdy_pct);
      m_acc = ifc.imem_req_valid && ifc.imem_req_ready;
      if (m_acc) begin
        chk("one_outstanding", {31'd0, pend}, 32'd0);
        paddr = ifc.imem_req_addr;
      end
    end
  end

  // ---------------- wrap instance: always-ready memory, decode always ready ----------------
  logic [31:0] ifw_q[$];
  bit          wacc = 0;
  logic [31:0] waddr = 0;
  initial begin
    ifw.imem_req_ready = 1'b1;
    ifw.instr_ready    = 1'b1;
    ifw.redirect_valid = 1'b0;
    ifw.redirect_pc    = 32'h0;
    ifw.imem_rsp_valid = 1'b0;
    ifw.imem_rsp_data  = 32'h0;
    forever begin
      @(posedge clk); #1;
      ifw.imem_rsp_valid = wacc;
      ifw.imem_rsp_data  = waddr ^ 32'h1357_9BDF;
      wacc = ifw.imem_req_valid;
      if (wacc) begin
        waddr = ifw.imem_req_addr;
        ifw_q.push_back(waddr);
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  // Expected stream: sequential from the last delivered pc, restarted at each
  // redirect target (word aligned) or at RESET_PC on reset.
  logic [31:0] expq[$];
  int          m_cnt = 0;
  int          hs_cyc[$];

  initial begin
    logic [31:0] e, d;
    forever begin
      @(negedge clk);
      if (rst) begin
        expq.delete();
        expq.push_back(32'h0);
        m_cnt = 0;
      end else begin
        chk("instr_count", ifc.instr_count, 32'(m_cnt));
        if (!ifc.instr_valid) chk("idle_instr_nop", ifc.instr, NOP);
        if (ifc.instr_valid && ifc.instr_ready) begin
          if (expq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_instr: got pc %h expected none", ifc.instr_pc);
            e = ifc.instr_pc;
          end else begin
            e = expq.pop_front();
            d = memf(e);
            chk("instr_pc", ifc.instr_pc, e);
            chk("instr", ifc.instr, d);
            chk("fields", {15'd0, ifc.funct7, ifc.funct3, ifc.opcode},
                {15'd0, d[31:25], d[14:12], d[6:0]});
          end
          m_cnt++;
          hs_cyc.push_back(cyc);
          expq.push_back(e + 32'd4);
        end
        if (ifc.redirect_valid) begin
          expq.delete();
          expq.push_back(ifc.redirect_pc & ~32'h3);
        end
      end
    end
  end

  // ---------------- driver ----------------
  logic [31:0] w_tgt = 0;

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0: return ifc.instr_valid;
      1: return ifc.imem_req_valid;
      2: return pend && (paddr == w_tgt);
      3: return ifc.imem_req_valid && m_acc;
      4: return ifc.imem_rsp_valid && !ifc.imem_req_valid && !ifc.instr_valid;
      5: return ifw_q.size() >= 2;
      7: return pend;
      8: return !pend;
      default: return 0;
    endcase
  endfunction

  task automatic wait_cond(input int sel, input string nm);
    int k = 0;
    while (!cond(sel) && k < 500) begin step(); k++; end
    if (k >= 500) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout_%s: got no event expected event within 500 cycles", nm);
    end
  endtask

  task automatic redirect(input logic [31:0] pc);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = pc;
    step();
    ifc.redirect_valid = 1'b0;
  endtask

  initial begin
    int exp_cnt;
    ifc.instr_ready    = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = 32'h0;
    rst = 1'b1;
    step(3);

    // reset values
    chk("rst_req_valid", {31'd0, ifc.imem_req_valid}, 0);
    chk("rst_instr_valid", {31'd0, ifc.instr_valid}, 0);
    chk("rst_instr", ifc.instr, NOP);
    chk("rst_instr_pc", ifc.instr_pc, 0);
    chk("rst_count", ifc.instr_count, 0);
    chk("rst_pc", ifc.imem_req_addr, 0);

    // basic stream: zero-latency memory, decode always ready
    ifc.instr_ready = 1'b1;
    rst = 1'b0;
    chk("no_req_before_edge", {31'd0, ifc.imem_req_valid}, 0);
    step();
    chk("first_req_valid", {31'd0, ifc.imem_req_valid}, 1);
    chk("first_req_addr", ifc.imem_req_addr, 32'h0);
    step(9);
    chk("count_after_3", ifc.instr_count, 32'd3);
    chk("hs_seen", 32'(hs_cyc.size()), 32'd3);
    if (hs_cyc.size() >= 3) begin
      chk("hs_spacing_1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
      chk("hs_spacing_2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);
    end

    // wrap instance
    wait_cond(5, "wrap_reqs");
    if (ifw_q.size() >= 2) begin
      chk("wrap_first_addr", ifw_q[0], 32'hFFFF_FFFC);
      chk("wrap_second_addr", ifw_q[1], 32'h0000_0000);
    end

    // field split and back-pressure
    ovr[32'h200] = 32'h4020_80B3;
    ifc.instr_ready = 1'b0;
    redirect(32'h200);
    wait_cond(0, "field_valid");
    chk("opcode", {25'd0, ifc.opcode}, 32'h33);
    chk("funct3", {29'd0, ifc.funct3}, 32'h0);
    chk("funct7", {25'd0, ifc.funct7}, 32'h20);
    repeat (5) begin
      step();
      chk("stall_valid", {31'd0, ifc.instr_valid}, 1);
      chk("stall_instr", ifc.instr, 32'h4020_80B3);
      chk("stall_pc", ifc.instr_pc, 32'h200);
      chk("stall_no_req", {31'd0, ifc.imem_req_valid}, 0);
    end
    ifc.instr_ready = 1'b1;
    step();

    // redirect while waiting for a response
    lat_lo = 2; lat_hi = 2;
    ovr[32'h10] = 32'hDEAD_BEEF;
    w_tgt = 32'h10;
    redirect(32'h10);
    wait_cond(2, "wait_0x10");
    redirect(32'h103);
    wait_cond(1, "req_after_drain");
    chk("redir_wait_addr", ifc.imem_req_addr, 32'h100);
    wait_cond(0, "instr_0x100");
    chk("redir_wait_instr_pc", ifc.instr_pc, 32'h100);

    // (a) redirect with request acceptance
    lat_lo = 1; lat_hi = 1;
    wait_cond(3, "req_accept");
    redirect(32'h300);
    chk("drain_no_valid", {31'd0, ifc.instr_valid}, 0);
    wait_cond(1, "req_after_a");
    chk("redir_acc_addr", ifc.imem_req_addr, 32'h300);
    wait_cond(0, "instr_0x300");
    chk("redir_acc_instr_pc", ifc.instr_pc, 32'h300);

    // (b) redirect with response in WAIT
    wait_cond(4, "rsp_in_wait");
    redirect(32'h400);
    chk("redir_rsp_req", {31'd0, ifc.imem_req_valid}, 1);
    chk("redir_rsp_addr", ifc.imem_req_addr, 32'h400);
    chk("redir_rsp_no_valid", {31'd0, ifc.instr_valid}, 0);

    // (c) redirect in HOLD together with a handshake
    ifc.instr_ready = 1'b0;
    wait_cond(0, "hold_c");
    exp_cnt = m_cnt;
    ifc.instr_ready = 1'b1;
    redirect(32'h500);
    chk("hold_redir_count", ifc.instr_count, 32'(exp_cnt + 1));
    chk("hold_redir_valid", {31'd0, ifc.instr_valid}, 0);
    chk("hold_redir_req", {31'd0, ifc.imem_req_valid}, 1);
    chk("hold_redir_addr", ifc.imem_req_addr, 32'h500);

    // async reset while a response is owed
    lat_lo = 4; lat_hi = 4;
    wait_cond(7, "pend_for_reset");
    mem_hold = 1;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, ifc.instr_valid}, 0);
    chk("async_rst_pc", ifc.imem_req_addr, 32'h0);
    chk("async_rst_count", ifc.instr_count, 32'h0);
    chk("async_rst_req", {31'd0, ifc.imem_req_valid}, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    wait_cond(8, "stale_rsp");
    mem_hold = 0;
    wait_cond(1, "req_after_reset");
    chk("restart_addr", ifc.imem_req_addr, 32'h0);
    wait_cond(0, "instr_after_reset");
    chk("restart_instr_pc", ifc.instr_pc, 32'h0);

    // randomized traffic
    rdy_pct = 70; lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 1500; i++) begin
      ifc.instr_ready    = ($urandom_range(99, 0) < 60);
      ifc.redirect_valid = ($urandom_range(99, 0) < 8);
      ifc.redirect_pc    = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15, 0)))
                                                      : $urandom;
      step();
    end
    ifc.redirect_valid = 1'b0;
    ifc.instr_ready    = 1'b1;
    step(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
